// File: rtl/mmio_io_hub_pkg.sv
// Shared constants for the MMIO I/O hub: register offsets,
// KEY_STATUS field positions and IRQ_EN bit indices.
package io_hub_pkg;

  localparam logic [2:0] OFS_SW      = 3'd0;
  localparam logic [2:0] OFS_BTNLVL  = 3'd1;
  localparam logic [2:0] OFS_BTNEDGE = 3'd2;
  localparam logic [2:0] OFS_KEYST   = 3'd3;
  localparam logic [2:0] OFS_KEYDATA = 3'd4;
  localparam logic [2:0] OFS_LED     = 3'd5;
  localparam logic [2:0] OFS_SEG     = 3'd6;
  localparam logic [2:0] OFS_IRQEN   = 3'd7;

  localparam int KS_EMPTY = 16;
  localparam int KS_FULL  = 17;
  localparam int KS_OVF   = 24;

  localparam int IE_EDGE = 0;
  localparam int IE_KEY  = 1;
  localparam int IE_OVF  = 2;

endpackage

// File: rtl/mmio_io_hub_if.sv
// Load/store bus between the core and the I/O hub.
// The master drives strobes; the hub answers with registered data.
interface mmio_io_hub_if;

  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_rd;
  logic        bus_wr;
  logic [31:0] bus_rdata;
  logic        bus_rvalid;
  logic        bus_err;

  modport master (
    output bus_addr, bus_wdata, bus_rd, bus_wr,
    input  bus_rdata, bus_rvalid, bus_err
  );

  modport slave (
    input  bus_addr, bus_wdata, bus_rd, bus_wr,
    output bus_rdata, bus_rvalid, bus_err
  );

endinterface

// File: rtl/mmio_io_hub_fifo.sv
// Synchronous FIFO with combinational head and occupancy count.
// A pop while full frees the slot so a same-cycle push is accepted.
module io_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_push;
  logic             w_pop;

  assign count = r_wptr - r_rptr;
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign dout  = r_mem[r_rptr[AW-1:0]];

  assign w_pop  = pop & ~empty;
  assign w_push = push & (~full | w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mmio_io_hub.sv
// MMIO hub: window decode, output latches, sticky button edges,
// keycode FIFO with overflow flag, registered read port and irq.
module mmio_io_hub
  import io_hub_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_FC00,
  parameter int          SW_W       = 12,
  parameter int          N_BTN      = 4,
  parameter int          LED_W      = 16,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  mmio_io_hub_if.slave     bus,
  input  logic [SW_W-1:0]  sw_in,
  input  logic [N_BTN-1:0] btn_in,
  input  logic             key_valid,
  input  logic [7:0]       key_code,
  output logic [LED_W-1:0] led_out,
  output logic [31:0]      seg_out,
  output logic             irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]      r_rdata;
  logic             r_rvalid;
  logic             r_err;
  logic [LED_W-1:0] r_led;
  logic [31:0]      r_seg;
  logic [2:0]       r_irq_en;
  logic [N_BTN-1:0] r_btn_prev;
  logic [N_BTN-1:0] r_edge;
  logic             r_ovf;
  logic             r_irq;

  logic             w_hit;
  logic [2:0]       w_ofs;
  logic             w_rd_ok;
  logic             w_wr_ok;
  logic             w_err;
  logic             w_pop;
  logic             w_edge_clr;
  logic [N_BTN-1:0] w_new_edge;
  logic             w_ovf_set;
  logic             w_ovf_clr;
  logic [7:0]       w_dout;
  logic [CW-1:0]    w_count;
  logic             w_empty;
  logic             w_full;
  logic [31:0]      w_rmux;
  logic             w_unused;

  assign w_unused = ^bus.bus_addr[1:0];

  assign w_hit   = (bus.bus_addr[31:5] == BASE_ADDR[31:5]);
  assign w_ofs   = bus.bus_addr[4:2];
  assign w_rd_ok = bus.bus_rd & ~bus.bus_wr & w_hit;
  assign w_wr_ok = bus.bus_wr & w_hit;
  assign w_err   = ((bus.bus_rd | bus.bus_wr) & ~w_hit)
                 | (bus.bus_rd & bus.bus_wr);

  assign w_pop      = w_rd_ok & (w_ofs == OFS_KEYDATA);
  assign w_edge_clr = w_rd_ok & (w_ofs == OFS_BTNEDGE);
  assign w_new_edge = btn_in & ~r_btn_prev;

  // A pop in the same cycle makes room, so that push is not an overflow.
  assign w_ovf_set = key_valid & w_full & ~w_pop;
  assign w_ovf_clr = w_wr_ok & (w_ofs == OFS_KEYST)
                   & bus.bus_wdata[KS_OVF];

  io_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (key_valid),
    .pop   (w_pop),
    .din   (key_code),
    .dout  (w_dout),
    .count (w_count),
    .empty (w_empty),
    .full  (w_full)
  );

  always_comb begin
    w_rmux = '0;
    unique case (w_ofs)
      OFS_SW:      w_rmux[SW_W-1:0] = sw_in;
      OFS_BTNLVL:  w_rmux[N_BTN-1:0] = btn_in;
      OFS_BTNEDGE: w_rmux[N_BTN-1:0] = r_edge;
      OFS_KEYST: begin
        w_rmux[CW-1:0]   = w_count;
        w_rmux[KS_EMPTY] = w_empty;
        w_rmux[KS_FULL]  = w_full;
        w_rmux[KS_OVF]   = r_ovf;
      end
      OFS_KEYDATA: if (!w_empty) w_rmux[7:0] = w_dout;
      OFS_LED:     w_rmux[LED_W-1:0] = r_led;
      OFS_SEG:     w_rmux = r_seg;
      OFS_IRQEN:   w_rmux[2:0] = r_irq_en;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata    <= '0;
      r_rvalid   <= 1'b0;
      r_err      <= 1'b0;
      r_led      <= '0;
      r_seg      <= '0;
      r_irq_en   <= '0;
      r_btn_prev <= '0;
      r_edge     <= '0;
      r_ovf      <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      r_rvalid <= w_rd_ok;
      r_err    <= w_err;
      if (w_rd_ok)
        r_rdata <= w_rmux;
      else if (bus.bus_rd && !w_hit)
        r_rdata <= '0;
      r_btn_prev <= btn_in;
      // Fresh edges survive a clearing read.
      r_edge <= (w_edge_clr ? '0 : r_edge) | w_new_edge;
      if (w_wr_ok && w_ofs == OFS_LED)
        r_led <= bus.bus_wdata[LED_W-1:0];
      if (w_wr_ok && w_ofs == OFS_SEG)
        r_seg <= bus.bus_wdata;
      if (w_wr_ok && w_ofs == OFS_IRQEN)
        r_irq_en <= bus.bus_wdata[2:0];
      if (w_ovf_set)
        r_ovf <= 1'b1;
      else if (w_ovf_clr)
        r_ovf <= 1'b0;
      r_irq <= (r_irq_en[IE_EDGE] & |r_edge)
             | (r_irq_en[IE_KEY]  & ~w_empty)
             | (r_irq_en[IE_OVF]  & r_ovf);
    end
  end

  assign bus.bus_rdata  = r_rdata;
  assign bus.bus_rvalid = r_rvalid;
  assign bus.bus_err    = r_err;
  assign led_out        = r_led;
  assign seg_out        = r_seg;
  assign irq            = r_irq;

endmodule
